// File: rtl/serial_tx.sv
// serial_tx: framed serial transmitter (start bit, LSB-first payload, stop bit)
// with every output registered and an asynchronous active-low reset.
module serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W = 8
) (
  input  logic              clc,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic tx_q, tx_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic wrap;
  assign wrap = baud_q == BAUD_MAX;
  assign in_ready = ready_q;
  assign tx = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  always_ff @(posedge clc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    baud_d = (state_q == IDLE || wrap) ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (in_valid && ready_q) begin
        state_d = START;
        shift_d = in_data;
      end
      START: if (wrap) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (wrap) begin
        if (bit_q == BIT_MAX) state_d = STOP;
        else begin
          bit_d = bit_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      default: if (wrap) state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    busy_d = state_d != IDLE;
    ready_d = state_d == IDLE;
    done_d = state_d == STOP && baud_d == BAUD_MAX;
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: frame-level model of serial_tx checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_serial_tx;
  localparam int CPB = 4;
  localparam int DW = 8;
  typedef struct packed {logic tx; logic done;} exp_t;
  logic clc = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, tx, busy, done;
  logic in_valid1 = 1'b0;
  logic [0:0] in_data1 = '0;
  logic in_ready1, tx1, busy1, done1;
  int chk = 0;
  int err = 0;
  exp_t q[$];
  bit was_idle;
  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) u0 (
    .clc(clc), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
  );
  serial_tx #(.CLKS_PER_BIT(2), .DATA_W(1)) u1 (
    .clc(clc), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .done(done1)
  );
  always #5 clc = ~clc;
  // Model: a frame is a list of per-cycle line values queued when a word is accepted.
  always @(posedge clc or negedge rst_n) begin
    if (!rst_n) q.delete();
    else begin
      was_idle = q.size() == 0;
      if (!was_idle) void'(q.pop_front());
      if (was_idle && in_valid)
        for (int k = 0; k < DW + 2; k++)
          for (int c = 0; c < CPB; c++)
            q.push_back({(k == 0) ? 1'b0 : (k == DW + 1) ? 1'b1 : in_data[k-1],
                         k == DW + 1 && c == CPB - 1});
    end
  end
  task automatic lit(input string nm, input int act, input int exp);
    chk++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d need %0d", nm, act, exp);
    end
  endtask
  task automatic capture(input int n, output logic [9:0] bits, output int busy_n,
                         output int done_at, output int ready_n);
    bits = '0;
    busy_n = 0;
    done_at = -1;
    ready_n = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 40 && i % 4 == 1) bits[i/4] = tx;
      busy_n += int'(busy);
      ready_n += int'(in_ready);
      if (done && done_at < 0) done_at = i;
      @(negedge clc);
    end
  endtask
  initial begin
    logic [9:0] bits;
    int bn, da, rn;
    logic [5:0] e1;
    fork
      forever begin
        @(negedge clc);
        chk++;
        if ({tx, busy, in_ready, done} !==
            (q.size() > 0 ? {q[0].tx, 1'b1, 1'b0, q[0].done} : 4'b1010)) begin
          err++;
          $display("FAIL cycle t=%0t tx/busy/ready/done got %b need %b", $time,
                   {tx, busy, in_ready, done},
                   q.size() > 0 ? {q[0].tx, 1'b1, 1'b0, q[0].done} : 4'b1010);
        end
      end
      begin
        repeat (3) @(negedge clc);
        lit("reset_tx", int'(tx), 1);
        lit("reset_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        repeat (100) @(negedge clc);
        in_valid = 1'b1;
        in_data = 8'hA5;
        @(negedge clc);
        in_valid = 1'b0;
        capture(44, bits, bn, da, rn);
        lit("a5_bits", int'(bits), int'(10'b1101001010));
        lit("a5_busy_cycles", bn, 40);
        lit("a5_done_index", da, 39);
        in_data = 8'h00;
        in_valid = 1'b1;
        @(negedge clc);
        in_data = 8'hFF;
        capture(81, bits, bn, da, rn);
        in_valid = 1'b0;
        lit("b2b_bits0", int'(bits), int'(10'b1000000000));
        lit("b2b_busy_cycles", bn, 80);
        lit("b2b_ready_cycles", rn, 1);
        repeat (4) @(negedge clc);
        in_data = 8'h96;
        in_valid = 1'b1;
        @(negedge clc);
        for (int i = 0; i < 40; i++) begin
          in_valid = i[0];
          in_data = 8'(i * 37);
          @(negedge clc);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clc);
        in_data = 8'hF0;
        in_valid = 1'b1;
        @(negedge clc);
        in_valid = 1'b0;
        repeat (16) @(negedge clc);
        lit("pre_reset_tx", int'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        lit("abort_tx", int'(tx), 1);
        lit("abort_busy", int'(busy), 0);
        lit("abort_ready", int'(in_ready), 1);
        repeat (2) @(negedge clc);
        rst_n = 1'b1;
        in_data = 8'h3C;
        in_valid = 1'b1;
        @(negedge clc);
        in_valid = 1'b0;
        capture(44, bits, bn, da, rn);
        lit("3c_bits", int'(bits), int'(10'b1001111000));
        lit("3c_busy_cycles", bn, 40);
        in_valid1 = 1'b1;
        in_data1 = 1'b1;
        @(negedge clc);
        in_valid1 = 1'b0;
        e1 = 6'b111100;
        for (int i = 0; i < 6; i++) begin
          lit($sformatf("small_tx%0d", i), int'(tx1), int'(e1[i]));
          lit($sformatf("small_done%0d", i), int'(done1), int'(i == 5));
          @(negedge clc);
        end
        lit("small_idle_ready", int'(in_ready1), 1);
        lit("small_idle_busy", int'(busy1), 0);
        repeat (2) @(negedge clc);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
